// File: rtl/fifo_stream_arbiter.sv
// fifo_stream_arbiter: merges N first-word-fall-through source FIFOs into one FWFT stream
module fifo_stream_arbiter #(
  parameter int CHANNELS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int BURST_MAX     = 1,
  parameter int CH_BITS       = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                           BUS_CLK,
  input  logic                           BUS_RST,
  input  logic [CHANNELS-1:0]            CHANNEL_ENABLE,
  input  logic [CHANNELS-1:0]            SRC_FIFO_EMPTY,
  input  logic [CHANNELS*DATA_WIDTH-1:0] SRC_FIFO_DATA,
  output logic [CHANNELS-1:0]            SRC_FIFO_READ,
  input  logic                           FIFO_READ,
  output logic                           FIFO_EMPTY,
  output logic [DATA_WIDTH-1:0]          FIFO_DATA,
  output logic                           GRANT_VALID,
  output logic [CH_BITS-1:0]             GRANT_CH
);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t                state_q;
  logic [CH_BITS-1:0]    grant_ch_q, last_ch_q, grant_ch_d, base;
  logic [7:0]            cnt_q;
  logic [CHANNELS-1:0]   req;
  logic [DATA_WIDTH-1:0] words [CHANNELS];
  logic                  any_req, head_empty, pop, rel;
  // request vector and per-channel head words
  always_comb begin
    req = ~SRC_FIFO_EMPTY & CHANNEL_ENABLE;
    any_req = |req;
    for (int i = 0; i < CHANNELS; i++) words[i] = SRC_FIFO_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // merged output path straight from the registered grant; a disabled head counts as empty
  always_comb begin
    head_empty = SRC_FIFO_EMPTY[grant_ch_q] | ~CHANNEL_ENABLE[grant_ch_q];
    GRANT_VALID = state_q == GRANTED;
    GRANT_CH = grant_ch_q;
    FIFO_EMPTY = ~GRANT_VALID | head_empty;
    FIFO_DATA = GRANT_VALID ? words[grant_ch_q] : '0;
    pop = FIFO_READ & ~FIFO_EMPTY;
    SRC_FIFO_READ = pop ? CHANNELS'(1) << grant_ch_q : '0;
    rel = GRANT_VALID & ((pop & (cnt_q == 8'(BURST_MAX - 1))) | head_empty);
  end
  // next grant: search after the channel just released (or last released when idle)
  always_comb begin
    grant_ch_d = '0;
    base = GRANT_VALID ? grant_ch_q : last_ch_q;
    if (PRIORITY_MODE != 0)
      for (int i = CHANNELS - 1; i >= 0; i--) grant_ch_d = req[i] ? CH_BITS'(i) : grant_ch_d;
    else
      for (int k = CHANNELS; k >= 1; k--)
        grant_ch_d = req[CH_BITS'((int'(base) + k) % CHANNELS)] ? CH_BITS'((int'(base) + k) % CHANNELS) : grant_ch_d;
  end
  // grant FSM: arbitrate when idle or on release, otherwise count burst pops
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state_q <= IDLE;
      grant_ch_q <= '0;
      cnt_q <= '0;
      last_ch_q <= CH_BITS'(CHANNELS - 1);
    end else if (state_q == IDLE || rel) begin
      if (rel) last_ch_q <= grant_ch_q;
      state_q <= any_req ? GRANTED : IDLE;
      if (any_req) grant_ch_q <= grant_ch_d;
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end
endmodule
